// File: rtl/buffer_controller_if.sv
// Handshake and status bundle between the stream endpoints and buffer_controller.
// The master side drives the streams; the slave side is the controller.
interface buffer_controller_if #(parameter int SIZE = 16);
  localparam int BIT = $clog2(SIZE);

  logic           start;
  logic           in_valid;
  logic           in_last;
  logic           in_ready;
  logic           out_ready;
  logic           out_valid;
  logic           ld;
  logic [BIT-1:0] write_add;
  logic [BIT-1:0] read_add;
  logic [BIT:0]   count;
  logic           full;
  logic           empty;
  logic           busy;
  logic           done;

  modport master (
    output start, in_valid, in_last, out_ready,
    input  in_ready, out_valid, ld, write_add, read_add, count, full, empty, busy, done
  );

  modport slave (
    input  start, in_valid, in_last, out_ready,
    output in_ready, out_valid, ld, write_add, read_add, count, full, empty, busy, done
  );
endinterface

// File: rtl/buffer_controller.sv
// Pointer/occupancy sequencer for the circular Buffer: K-word writes, J-word reads,
// one stream framed as start -> last block -> drain -> done.
//
// state | meaning
// IDLE  | no stream; in_ready/out_valid low, waits for start
// RUN   | accepting K-word blocks and serving J-word reads
// DRAIN | last block seen; reads only until fewer than J words remain
module buffer_controller #(
  parameter int SIZE = 16,
  parameter int K    = 8,
  parameter int J    = 4
) (
  input logic                clk,
  input logic                rst,
  buffer_controller_if.slave bus
);
  localparam int BIT = $clog2(SIZE);
  localparam logic [BIT:0] SIZE_C = (BIT+1)'(SIZE);
  localparam logic [BIT:0] K_C    = (BIT+1)'(K);
  localparam logic [BIT:0] J_C    = (BIT+1)'(J);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t         state;
  logic [BIT-1:0] wr_ptr;
  logic [BIT-1:0] rd_ptr;
  logic [BIT:0]   count;
  logic           full_q;
  logic           empty_q;
  logic           busy_q;

  logic           wr_hs;
  logic           rd_hs;
  logic           in_ready_c;
  logic           out_valid_c;
  logic           done_c;
  logic [BIT:0]   count_nxt;

  // Sum fits in BIT+1 bits because both operands are below 2^BIT; SIZE need not be a power of two.
  function automatic logic [BIT-1:0] ptr_adv(input logic [BIT-1:0] p, input logic [BIT:0] inc);
    logic [BIT:0] s;
    s = {1'b0, p} + inc;
    if (s >= SIZE_C) s = s - SIZE_C;
    return s[BIT-1:0];
  endfunction

  always_comb begin
    in_ready_c  = (state == RUN) && ((SIZE_C - count) >= K_C);
    out_valid_c = (state != IDLE) && (count >= J_C);
    wr_hs       = bus.in_valid && in_ready_c;
    rd_hs       = out_valid_c && bus.out_ready;
    done_c      = (state == DRAIN) && (count < J_C) && !rd_hs;
    count_nxt   = count + (wr_hs ? K_C : '0) - (rd_hs ? J_C : '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state   <= RUN;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        RUN, DRAIN: begin
          if (done_c) begin
            // Residual words short of a full read block are dropped here.
            state   <= IDLE;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            if (wr_hs) wr_ptr <= ptr_adv(wr_ptr, K_C);
            if (rd_hs) rd_ptr <= ptr_adv(rd_ptr, J_C);
            count   <= count_nxt;
            full_q  <= (count_nxt == SIZE_C);
            empty_q <= (count_nxt == '0);
            if (state == RUN && wr_hs && bus.in_last) state <= DRAIN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.ld        = wr_hs;
  assign bus.done      = done_c;
  assign bus.write_add = wr_ptr;
  assign bus.read_add  = rd_ptr;
  assign bus.count     = count;
  assign bus.full      = full_q;
  assign bus.empty     = empty_q;
  assign bus.busy      = busy_q;
endmodule
